async_fifo_rd_stream: RTL and testbench

Read-side streaming adapter for the asynchronous FIFO, living entirely in the read clock domain. It pulls words from the FIFO read port (`rempty`/`rinc`/`rdata`) and presents them downstream as a registered valid/ready stream through a 2-entry skid buffer. It sustains one word per cycle, and `m_ready` never reaches `rinc` combinationally. It also provides a synchronous flush and a wrapping count of delivered words.

---
 rtl/async_fifo_rd_stream.sv | 118 +++++++++++
 tb/tb_async_fifo_rd_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
// Read-domain adapter between the async FIFO read port and a registered
// valid/ready stream. A 2-entry skid buffer (head + tail register) lets the
// FIFO pop decision depend only on local state, so m_ready has no
// combinational path to rinc. Also provides a synchronous flush and a
// wrapping count of completed downstream handshakes.
module async_fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    input  logic             flush,
    output logic [1:0]       buf_count,
    output logic [CNT_W-1:0] words_out
);

    // Buffer occupancy; the encoding is exactly the buffered-entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    logic [DSIZE-1:0] w_head_nxt;
    logic [DSIZE-1:0] w_tail_nxt;
    logic [CNT_W-1:0] r_words;
    logic             w_push;
    logic             w_pop;

    // Pop the FIFO only when a word is there, no flush is pending and a slot
    // is guaranteed free regardless of what downstream does this cycle.
    assign w_push    = rrst_n & ~rempty & ~flush & (r_state != ST_FULL);
    assign w_pop     = (r_state != ST_EMPTY) & m_ready;

    assign rinc      = w_push;
    assign m_valid   = (r_state != ST_EMPTY);
    assign m_data    = r_head;
    assign buf_count = r_state;
    assign words_out = r_words;

    // Next occupancy and entry contents from the push/pop combination.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_head_nxt  = rdata;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_head_nxt = rdata;
                end else if (w_push) begin
                    w_tail_nxt  = rdata;
                    w_state_nxt = ST_FULL;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // rinc is held low here, so only a pop can move the state.
                if (w_pop) begin
                    w_head_nxt  = r_tail;
                    w_state_nxt = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush drops every buffered entry; m_data keeps its last value.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_head_nxt  = r_head;
        end
    end

    // Occupancy, head word and handshake counter; synchronous reset.
    always_ff @(posedge rclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rrst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_words <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            if (w_pop) begin
                r_words <= r_words + CNT_W'(1);
            end
        end
    end

    // Tail entry storage.
    always_ff @(posedge rclk) begin
        // NOTE: the tail is pure data qualified by r_state, so it needs no
        // reset; only control state and the visible m_data are cleared.
        r_tail <= w_tail_nxt;
    end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// tb_async_fifo_rd_stream
// Directed and randomized checks of the read-side stream adapter. A small
// source-FIFO model drives rempty/rdata, a buffer model tracks the expected
// skid-buffer contents, and every delivered word is logged for ordering.
module tb_async_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       flush;
    logic [1:0] buf_count;
    logic [15:0] words_out;

    logic       w4_rinc;
    logic       w4_m_valid;
    logic [7:0] w4_m_data;
    logic [1:0] w4_buf_count;
    logic [3:0] w4_words_out;

    async_fifo_rd_stream #(.DSIZE(8), .CNT_W(16)) u_dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .flush     (flush),
        .buf_count (buf_count),
        .words_out (words_out)
    );

    // Narrow-counter copy sharing all stimulus, used for the wrap check.
    async_fifo_rd_stream #(.DSIZE(8), .CNT_W(4)) u_dut_w4 (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (w4_rinc),
        .m_valid   (w4_m_valid),
        .m_ready   (m_ready),
        .m_data    (w4_m_data),
        .flush     (flush),
        .buf_count (w4_buf_count),
        .words_out (w4_words_out)
    );

    always #5 rclk = ~rclk;

    logic [7:0] src_q[$];
    logic [7:0] mbuf[$];
    logic [7:0] log_q[$];
    logic [7:0] gen_q[$];
    int         cnt;
    bit         gate;
    bit         model_ok;
    int         rinc_pulses;
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: present source, check against model, advance model.
    task automatic cycle();
        logic       s_rinc;
        logic       s_flush;
        logic       s_ready;
        logic       s_rst;
        logic [7:0] s_rdata;
        rempty = gate || (src_q.size() == 0);
        rdata  = (src_q.size() != 0) ? src_q[0] : 8'h00;
        #1;
        s_rinc  = rinc;
        s_flush = flush;
        s_ready = m_ready;
        s_rst   = rrst_n;
        s_rdata = rdata;
        check("rinc", 32'(rinc), 32'(rrst_n && !rempty && !flush && (mbuf.size() < 2)));
        if (model_ok) begin
            check("buf_count", 32'(buf_count), 32'(mbuf.size()));
            check("m_valid", 32'(m_valid), 32'(mbuf.size() != 0));
            if (mbuf.size() != 0) check("m_data", 32'(m_data), 32'(mbuf[0]));
            check("words_out", 32'(words_out), 32'(cnt % 65536));
            check("words_out_w4", 32'(w4_words_out), 32'(cnt % 16));
        end
        if (rinc) rinc_pulses++;
        @(posedge rclk);
        if (!s_rst) begin
            mbuf.delete();
            cnt      = 0;
            model_ok = 1'b1;
        end else begin
            if (mbuf.size() != 0 && s_ready) begin
                log_q.push_back(mbuf.pop_front());
                cnt++;
            end
            if (s_flush) mbuf.delete();
            if (s_rinc) begin
                mbuf.push_back(s_rdata);
                if (src_q.size() != 0) void'(src_q.pop_front());
            end
        end
        @(negedge rclk);
    endtask

    initial begin
        int guard;
        int bad;
        n_tests     = 0;
        n_fail      = 0;
        cnt         = 0;
        model_ok    = 1'b0;
        gate        = 1'b0;
        rinc_pulses = 0;
        rrst_n      = 1'b0;
        m_ready     = 1'b0;
        flush       = 1'b0;
        rempty      = 1'b1;
        rdata       = 8'h00;
        @(negedge rclk);

        // Reset with a non-empty FIFO: rinc must stay low throughout.
        src_q.push_back(8'h55);
        for (int i = 0; i < 3; i++) cycle();
        check("rst_pulses", 32'(rinc_pulses), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_count", 32'(buf_count), 32'd0);
        check("rst_words", 32'(words_out), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        src_q.delete();
        rrst_n = 1'b1;
        cycle();

        // Streaming 0x11..0x18 with m_ready high: one word per cycle.
        m_ready = 1'b1;
        log_q.delete();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h11 + i));
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(8'h11 + i));
        end
        cycle();
        check("stream_count", 32'(buf_count), 32'd0);
        check("stream_words", 32'(words_out), 32'd8);

        // Backpressure: 5 words queued, m_ready low for 6 cycles.
        m_ready     = 1'b0;
        rinc_pulses = 0;
        log_q.delete();
        for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h21 + i));
        for (int i = 0; i < 6; i++) cycle();
        check("bp_pulses", 32'(rinc_pulses), 32'd2);
        check("bp_count", 32'(buf_count), 32'd2);
        check("bp_head", 32'(m_data), 32'h21);
        m_ready = 1'b1;
        guard   = 0;
        while (log_q.size() < 5 && guard < 20) begin
            cycle();
            guard++;
        end
        check("bp_delivered", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            check("bp_order", 32'(log_q[i]), 32'(8'h21 + i));
        check("bp_words", 32'(words_out), 32'd13);

        // Flush with a same-edge handshake: A0 counted, A1 dropped.
        m_ready = 1'b0;
        log_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hA0 + i));
        cycle();
        cycle();
        check("fl_count_pre", 32'(buf_count), 32'd2);
        m_ready = 1'b1;
        flush   = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_words", 32'(words_out), 32'd14);
        check("fl_count", 32'(buf_count), 32'd0);
        check("fl_first", 32'(log_q.size() > 0 ? log_q[0] : 8'h00), 32'hA0);
        cycle();
        check("fl_next_valid", 32'(m_valid), 32'd1);
        check("fl_next_data", 32'(m_data), 32'hA2);
        guard = 0;
        while (log_q.size() < 3 && guard < 10) begin
            cycle();
            guard++;
        end
        check("fl_tail", 32'(log_q.size() > 2 ? log_q[2] : 8'h00), 32'hA3);
        check("fl_words_end", 32'(words_out), 32'd16);

        // Counter wrap: reset, then 17 handshakes; 4-bit counter reads 1.
        rrst_n = 1'b0;
        cycle();
        cycle();
        rrst_n = 1'b1;
        for (int i = 0; i < 17; i++) src_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 20; i++) cycle();
        check("wrap_w4", 32'(w4_words_out), 32'd1);
        check("wrap_w16", 32'(words_out), 32'd17);

        // Random source gaps and downstream stalls over 10,000 words.
        log_q.delete();
        gen_q.delete();
        guard = 0;
        while (log_q.size() < 10000 && guard < 60000) begin
            if (gen_q.size() < 10000 && src_q.size() < 4) begin
                logic [7:0] w;
                w = 8'($urandom);
                src_q.push_back(w);
                gen_q.push_back(w);
            end
            gate    = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            cycle();
            guard++;
        end
        gate = 1'b0;
        check("rand_delivered", 32'(log_q.size()), 32'd10000);
        bad = 0;
        for (int i = 0; i < log_q.size() && i < gen_q.size(); i++)
            if (log_q[i] !== gen_q[i]) bad++;
        check("rand_order", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
